// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue decision over the two buffer head instructions plus ID-stage slot registers.
module issue_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall_i,
    input  logic [31:0]      buf_inst1_i,
    input  logic [31:0]      buf_inst2_i,
    input  logic [31:0]      buf_addr1_i,
    input  logic [31:0]      buf_addr2_i,
    input  logic             buf_issue_ok_i,
    output logic             issue_o,
    output logic             issue_mode_o,
    output logic [31:0]      id_inst1_o,
    output logic [31:0]      id_inst2_o,
    output logic [31:0]      id_addr1_o,
    output logic [31:0]      id_addr2_o,
    output logic             id_valid1_o,
    output logic             id_valid2_o,
    output logic [CNT_W-1:0] single_cnt_o,
    output logic [CNT_W-1:0] dual_cnt_o
);
    // {dest[4:0], branch, mem, priv, hilo_write, hilo_read}
    function automatic logic [9:0] f_dec(input logic [31:0] i);
        logic [5:0] op;
        logic [5:0] fn;
        logic       r0;
        logic       hw;
        logic       hr;
        logic       pr;
        logic       br;
        logic       mem;
        logic [4:0] d;
        op  = i[31:26];
        fn  = i[5:0];
        r0  = op == 6'h00;
        hw  = r0 && (fn inside {6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
        hr  = r0 && (fn == 6'h10 || fn == 6'h12);
        pr  = op == 6'h10 || (r0 && (fn == 6'h0C || fn == 6'h0D));
        br  = (op inside {[6'h01:6'h07]}) || (r0 && (fn == 6'h08 || fn == 6'h09));
        mem = op inside {[6'h20:6'h2E]};
        d   = r0 ? ((hw || pr || fn == 6'h08) ? 5'd0 : i[15:11])
            : (op inside {[6'h08:6'h0F], [6'h20:6'h25]}) ? i[20:16]
            : (op == 6'h03) ? 5'd31 : 5'd0;
        return {d, br, mem, pr, hw, hr};
    endfunction

    logic [9:0]       w_d1;
    logic [9:0]       w_d2;
    logic [4:0]       w_dst1;
    logic             w_raw;
    logic             w_waw;
    logic             w_dual;
    logic             r_ds;
    logic [31:0]      r_i1;
    logic [31:0]      r_i2;
    logic [31:0]      r_a1;
    logic [31:0]      r_a2;
    logic             r_v1;
    logic             r_v2;
    logic [CNT_W-1:0] r_sc;
    logic [CNT_W-1:0] r_dc;

    assign w_d1   = f_dec(buf_inst1_i);
    assign w_d2   = f_dec(buf_inst2_i);
    assign w_dst1 = w_d1[9:5];
    assign w_raw  = |w_dst1 && (buf_inst2_i[25:21] == w_dst1 || buf_inst2_i[20:16] == w_dst1);
    assign w_waw  = |w_dst1 && w_dst1 == w_d2[9:5];
    assign w_dual = ~(w_raw | w_waw | (w_d1[3] & w_d2[3]) | w_d2[4] | w_d1[2] | w_d2[2] | (w_d1[1] & w_d2[0]));

    assign issue_o      = buf_issue_ok_i & ~stall_i & ~flush & ~rst;
    assign issue_mode_o = w_dual & ~r_ds;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ds <= 1'b0;
            r_i1 <= '0;
            r_i2 <= '0;
            r_a1 <= '0;
            r_a2 <= '0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_sc <= '0;
            r_dc <= '0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_ds <= 1'b0;
        end else if (issue_o) begin
            r_i1 <= buf_inst1_i;
            r_i2 <= buf_inst2_i;
            r_a1 <= buf_addr1_i;
            r_a2 <= buf_addr2_i;
            r_v1 <= 1'b1;
            r_v2 <= issue_mode_o;
            // a lone branch leaves its delay slot for the next single issue
            r_ds <= ~r_ds & ~issue_mode_o & w_d1[4];
            if (issue_mode_o && ~&r_dc)
                r_dc <= r_dc + CNT_W'(1);
            if (!issue_mode_o && ~&r_sc)
                r_sc <= r_sc + CNT_W'(1);
        end else if (!stall_i) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end
    end

    assign id_inst1_o   = r_i1;
    assign id_inst2_o   = r_i2;
    assign id_addr1_o   = r_a1;
    assign id_addr2_o   = r_a2;
    assign id_valid1_o  = r_v1;
    assign id_valid2_o  = r_v2;
    assign single_cnt_o = r_sc;
    assign dual_cnt_o   = r_dc;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed and randomized checks of issue_ctrl against a behavioural pairing model.
module tb_issue_ctrl;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          stall_i;
    logic [31:0]   buf_inst1_i;
    logic [31:0]   buf_inst2_i;
    logic [31:0]   buf_addr1_i;
    logic [31:0]   buf_addr2_i;
    logic          buf_issue_ok_i;
    logic          issue_o;
    logic          issue_mode_o;
    logic [31:0]   id_inst1_o;
    logic [31:0]   id_inst2_o;
    logic [31:0]   id_addr1_o;
    logic [31:0]   id_addr2_o;
    logic          id_valid1_o;
    logic          id_valid2_o;
    logic [CW-1:0] single_cnt_o;
    logic [CW-1:0] dual_cnt_o;

    issue_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_i(stall_i),
        .buf_inst1_i(buf_inst1_i), .buf_inst2_i(buf_inst2_i),
        .buf_addr1_i(buf_addr1_i), .buf_addr2_i(buf_addr2_i),
        .buf_issue_ok_i(buf_issue_ok_i), .issue_o(issue_o), .issue_mode_o(issue_mode_o),
        .id_inst1_o(id_inst1_o), .id_inst2_o(id_inst2_o),
        .id_addr1_o(id_addr1_o), .id_addr2_o(id_addr2_o),
        .id_valid1_o(id_valid1_o), .id_valid2_o(id_valid2_o),
        .single_cnt_o(single_cnt_o), .dual_cnt_o(dual_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit          m_ds;
    bit          m_v1;
    bit          m_v2;
    logic [31:0] m_i1;
    logic [31:0] m_i2;
    logic [31:0] m_a1;
    logic [31:0] m_a2;
    int          m_sc;
    int          m_dc;

    function automatic logic [31:0] addu(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h21};
    endfunction

    function automatic logic [31:0] subu(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h23};
    endfunction

    function automatic bit is_r(input logic [31:0] x, input int f);
        return x[31:26] == 6'd0 && int'(x[5:0]) == f;
    endfunction

    function automatic int ref_dest(input logic [31:0] x);
        int op = int'(x[31:26]);
        if (op == 0) begin
            foreach (x[k]) ;
            if (is_r(x, 8) || is_r(x, 12) || is_r(x, 13) || is_r(x, 17) || is_r(x, 19) ||
                is_r(x, 24) || is_r(x, 25) || is_r(x, 26) || is_r(x, 27))
                return 0;
            return int'(x[15:11]);
        end
        if ((op >= 8 && op <= 15) || (op >= 32 && op <= 37)) return int'(x[20:16]);
        if (op == 3) return 31;
        return 0;
    endfunction

    function automatic bit ref_br(input logic [31:0] x);
        int op = int'(x[31:26]);
        return (op >= 1 && op <= 7) || is_r(x, 8) || is_r(x, 9);
    endfunction

    function automatic bit ref_mem(input logic [31:0] x);
        int op = int'(x[31:26]);
        return op >= 32 && op <= 46;
    endfunction

    function automatic bit ref_priv(input logic [31:0] x);
        return x[31:26] == 6'h10 || is_r(x, 12) || is_r(x, 13);
    endfunction

    function automatic bit ref_dual(input logic [31:0] a, input logic [31:0] b);
        int da = ref_dest(a);
        int db = ref_dest(b);
        bit hlw = is_r(a, 17) || is_r(a, 19) || is_r(a, 24) || is_r(a, 25) || is_r(a, 26) || is_r(a, 27);
        bit hlr = is_r(b, 16) || is_r(b, 18);
        if (da != 0 && (int'(b[25:21]) == da || int'(b[20:16]) == da)) return 0;
        if (da != 0 && da == db) return 0;
        if (ref_mem(a) && ref_mem(b)) return 0;
        if (ref_br(b)) return 0;
        if (ref_priv(a) || ref_priv(b)) return 0;
        if (hlw && hlr) return 0;
        return 1;
    endfunction

    function automatic bit exp_issue();
        return buf_issue_ok_i && !stall_i && !flush && !rst;
    endfunction

    function automatic bit exp_mode();
        return ref_dual(buf_inst1_i, buf_inst2_i) && !m_ds;
    endfunction

    task automatic model_reset();
        m_ds = 0; m_v1 = 0; m_v2 = 0;
        m_i1 = '0; m_i2 = '0; m_a1 = '0; m_a2 = '0;
        m_sc = 0; m_dc = 0;
    endtask

    task automatic drive(input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] a1,
                         input logic [31:0] a2, input bit ok, input bit st, input bit fl);
        buf_inst1_i = i1; buf_inst2_i = i2; buf_addr1_i = a1; buf_addr2_i = a2;
        buf_issue_ok_i = ok; stall_i = st; flush = fl;
    endtask

    task automatic tick();
        bit iss = exp_issue();
        bit md = exp_mode();
        @(posedge clk);
        #1;
        if (flush) begin
            m_v1 = 0; m_v2 = 0; m_ds = 0;
        end else if (iss) begin
            m_i1 = buf_inst1_i; m_i2 = buf_inst2_i; m_a1 = buf_addr1_i; m_a2 = buf_addr2_i;
            m_v1 = 1; m_v2 = md;
            if (md) m_dc = (m_dc < MAX) ? m_dc + 1 : MAX;
            else    m_sc = (m_sc < MAX) ? m_sc + 1 : MAX;
            if (m_ds) m_ds = 0;
            else if (!md && ref_br(buf_inst1_i)) m_ds = 1;
        end else if (!stall_i) begin
            m_v1 = 0; m_v2 = 0;
        end
    endtask

    task automatic test_reset();
        drive(addu(3, 1, 2), addu(4, 5, 6), 32'h10, 32'h14, 1, 0, 0);
        #1;
        n_chk++;
        if ({issue_o, id_valid1_o, id_valid2_o, id_inst1_o, id_addr1_o, single_cnt_o, dual_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: issue=%b v=%b%b inst1=%h addr1=%h sc=%0d dc=%0d, want all 0",
                     issue_o, id_valid1_o, id_valid2_o, id_inst1_o, id_addr1_o, single_cnt_o, dual_cnt_o);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        n_chk++;
        if (issue_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_issue: got %b want 1", issue_o);
        end
        drive(addu(3, 1, 2), addu(4, 5, 6), 32'h10, 32'h14, 0, 0, 0);
        tick();
    endtask

    task automatic test_dual();
        drive(addu(3, 1, 2), addu(4, 5, 6), 32'h1000, 32'h1004, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_o !== 1'b1 || issue_mode_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_decide: issue=%b mode=%b want 1 1", issue_o, issue_mode_o);
        end
        tick();
        n_chk++;
        if ({id_valid1_o, id_valid2_o, id_addr1_o, id_addr2_o, dual_cnt_o} !== {2'b11, 32'h1000, 32'h1004, CW'(1)}) begin
            n_fail++;
            $display("FAIL dual_slots: v=%b%b a1=%h a2=%h dc=%0d want 11 1000 1004 1",
                     id_valid1_o, id_valid2_o, id_addr1_o, id_addr2_o, dual_cnt_o);
        end
        drive(addu(3, 1, 2), addu(4, 5, 6), 32'h1008, 32'h100c, 0, 0, 0);
        #1;
        n_chk++;
        if (issue_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_issue: got %b want 0", issue_o);
        end
        tick();
        n_chk++;
        if ({id_valid1_o, id_valid2_o, dual_cnt_o} !== {2'b00, CW'(1)}) begin
            n_fail++;
            $display("FAIL bubble_slots: v=%b%b dc=%0d want 00 1", id_valid1_o, id_valid2_o, dual_cnt_o);
        end
    endtask

    task automatic test_raw();
        drive(addu(3, 1, 2), subu(4, 3, 6), 32'h2000, 32'h2004, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_o !== 1'b1 || issue_mode_o !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_decide: issue=%b mode=%b want 1 0", issue_o, issue_mode_o);
        end
        tick();
        n_chk++;
        if ({id_inst1_o, id_inst2_o, id_valid1_o, id_valid2_o, single_cnt_o} !==
            {addu(3, 1, 2), subu(4, 3, 6), 2'b10, CW'(1)}) begin
            n_fail++;
            $display("FAIL raw_slots: i1=%h i2=%h v=%b%b sc=%0d", id_inst1_o, id_inst2_o,
                     id_valid1_o, id_valid2_o, single_cnt_o);
        end
        drive(subu(4, 3, 6), addu(7, 1, 2), 32'h2004, 32'h2008, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_mode_o !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_followup_mode: got %b want 1", issue_mode_o);
        end
        tick();
        n_chk++;
        if (id_addr1_o !== 32'h2004 || id_valid2_o !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_followup_slots: a1=%h v2=%b want 2004 1", id_addr1_o, id_valid2_o);
        end
    endtask

    task automatic test_branch();
        drive({6'h04, 5'd1, 5'd2, 16'h4}, {6'h23, 5'd5, 5'd1, 16'h0}, 32'h3000, 32'h3004, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_mode_o !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_dual_mode: got %b want 1", issue_mode_o);
        end
        tick();
        drive({6'h03, 26'h40}, addu(8, 31, 2), 32'h3100, 32'h3104, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_mode_o !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_single_mode: got %b want 0", issue_mode_o);
        end
        tick();
        drive(addu(8, 31, 2), addu(9, 1, 2), 32'h3104, 32'h3108, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_mode_o !== 1'b0) begin
            n_fail++;
            $display("FAIL delay_slot_mode: got %b want 0", issue_mode_o);
        end
        tick();
        n_chk++;
        if ({id_inst1_o, id_valid1_o, id_valid2_o} !== {addu(8, 31, 2), 2'b10}) begin
            n_fail++;
            $display("FAIL delay_slot_slots: i1=%h v=%b%b", id_inst1_o, id_valid1_o, id_valid2_o);
        end
        drive(addu(9, 1, 2), addu(10, 4, 5), 32'h3108, 32'h310c, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_mode_o !== 1'b1) begin
            n_fail++;
            $display("FAIL after_delay_mode: got %b want 1", issue_mode_o);
        end
        tick();
        n_chk++;
        if (single_cnt_o !== CW'(m_sc) || dual_cnt_o !== CW'(m_dc)) begin
            n_fail++;
            $display("FAIL branch_counters: sc=%0d dc=%0d want %0d %0d", single_cnt_o, dual_cnt_o, m_sc, m_dc);
        end
    endtask

    task automatic test_stall_flush();
        drive({6'h03, 26'h80}, addu(8, 31, 2), 32'h4000, 32'h4004, 1, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(addu(3, 1, 2), addu(4, 5, 6), 32'h4100, 32'h4104, 1, 1, 0);
            #1;
            n_chk++;
            if (issue_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_issue[%0d]: got %b want 0", k, issue_o);
            end
            tick();
            n_chk++;
            if ({id_inst1_o, id_inst2_o, id_addr1_o, id_valid1_o, id_valid2_o} !==
                {6'h03, 26'h80, addu(8, 31, 2), 32'h4000, 2'b10}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: i1=%h i2=%h a1=%h v=%b%b", k, id_inst1_o,
                         id_inst2_o, id_addr1_o, id_valid1_o, id_valid2_o);
            end
        end
        drive(addu(3, 1, 2), addu(4, 5, 6), 32'h4100, 32'h4104, 1, 1, 1);
        #1;
        n_chk++;
        if (issue_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_issue: got %b want 0", issue_o);
        end
        tick();
        n_chk++;
        if ({id_valid1_o, id_valid2_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_valids: got %b%b want 00", id_valid1_o, id_valid2_o);
        end
        drive(addu(3, 1, 2), addu(4, 5, 6), 32'h5000, 32'h5004, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_mode_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clears_ds: mode=%b want 1", issue_mode_o);
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            drive(addu(3, 1, 2), addu(4, 5, 6), 32'h6000 + 8 * k, 32'h6004 + 8 * k, 1, 0, 0);
            tick();
        end
        n_chk++;
        if (dual_cnt_o !== CW'(15)) begin
            n_fail++;
            $display("FAIL dual_saturate: got %0d want 15", dual_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        drive(addu(3, 1, 2), addu(4, 5, 6), 32'h7000, 32'h7004, 1, 0, 0);
        tick();
        #2;
        rst = 1;
        #1;
        n_chk++;
        if ({issue_o, id_valid1_o, id_valid2_o, id_inst1_o, id_inst2_o, single_cnt_o, dual_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: issue=%b v=%b%b i1=%h i2=%h sc=%0d dc=%0d want all 0", issue_o,
                     id_valid1_o, id_valid2_o, id_inst1_o, id_inst2_o, single_cnt_o, dual_cnt_o);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        drive(addu(3, 1, 2), addu(4, 5, 6), 32'h8000, 32'h8004, 1, 0, 0);
        #1;
        n_chk++;
        if (issue_o !== 1'b1 || issue_mode_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_decide: issue=%b mode=%b want 1 1", issue_o, issue_mode_o);
        end
        tick();
        n_chk++;
        if ({id_valid1_o, id_valid2_o, id_addr1_o, dual_cnt_o, single_cnt_o} !== {2'b11, 32'h8000, CW'(1), CW'(0)}) begin
            n_fail++;
            $display("FAIL post_reset_issue: v=%b%b a1=%h dc=%0d sc=%0d", id_valid1_o, id_valid2_o,
                     id_addr1_o, dual_cnt_o, single_cnt_o);
        end
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [15:0] im = 16'($urandom);
        logic [5:0]  fn;
        logic [31:0] r;
        case ($urandom_range(0, 12))
            0: fn = 6'h21;  1: fn = 6'h23;  2: fn = 6'h08;  3: fn = 6'h09;
            4: fn = 6'h0C;  5: fn = 6'h0D;  6: fn = 6'h10;  7: fn = 6'h11;
            8: fn = 6'h12;  9: fn = 6'h13; 10: fn = 6'h18; 11: fn = 6'h1B;
            default: fn = 6'h2A;
        endcase
        case ($urandom_range(0, 9))
            0, 1, 2: r = {6'h00, rs, rt, rd, 5'd0, fn};
            3:       r = {6'h09, rs, rt, im};
            4:       r = {6'h23, rs, rt, im};
            5:       r = {6'h2B, rs, rt, im};
            6:       r = {5'b00010, 1'($urandom), rs, rt, im};
            7:       r = {5'b00001, 1'($urandom), 26'($urandom)};
            8:       r = {6'h01, rs, rt, im};
            default: r = {($urandom_range(0, 1) == 0) ? 6'h10 : 6'h0F, rs, rt, im};
        endcase
        return r;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(rnd_inst(), rnd_inst(), $urandom, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
            #1;
            n_chk++;
            if (issue_o !== exp_issue()) begin
                n_fail++;
                $display("FAIL rnd_issue cyc %0d: got %b want %b", n, issue_o, exp_issue());
            end
            n_chk++;
            if (issue_mode_o !== exp_mode()) begin
                n_fail++;
                $display("FAIL rnd_mode cyc %0d: i1=%h i2=%h got %b want %b", n, buf_inst1_i,
                         buf_inst2_i, issue_mode_o, exp_mode());
            end
            tick();
            n_chk++;
            if ({id_inst1_o, id_inst2_o, id_addr1_o, id_addr2_o, id_valid1_o, id_valid2_o} !==
                {m_i1, m_i2, m_a1, m_a2, m_v1, m_v2}) begin
                n_fail++;
                $display("FAIL rnd_slots cyc %0d: got %h %h %h %h %b%b want %h %h %h %h %b%b", n,
                         id_inst1_o, id_inst2_o, id_addr1_o, id_addr2_o, id_valid1_o, id_valid2_o,
                         m_i1, m_i2, m_a1, m_a2, m_v1, m_v2);
            end
            n_chk++;
            if (single_cnt_o !== CW'(m_sc) || dual_cnt_o !== CW'(m_dc)) begin
                n_fail++;
                $display("FAIL rnd_counters cyc %0d: sc=%0d dc=%0d want %0d %0d", n, single_cnt_o,
                         dual_cnt_o, m_sc, m_dc);
            end
        end
    endtask

    initial begin
        rst = 1;
        drive('0, '0, '0, '0, 0, 0, 0);
        model_reset();
        #12;
        test_reset();
        test_dual();
        test_raw();
        test_branch();
        test_stall_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
